// File: rtl/fb_scanout.sv
`timescale 1ns/1ps
// fb_fifo: small generic synchronous FIFO (DEPTH entries of W bits).
// Latency: a write is visible at rd_dat the cycle after it is accepted.
// Backpressure: rd_vld/rd_rdy handshake on the read side. The writer must not write while full.
// Ports: wr_vld/wr_dat push; rd_vld/rd_rdy/rd_dat pop; count = occupancy.
module fb_fifo #(
  parameter int W     = 27,
  parameter int DEPTH = 2,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_vld,
  input  logic [W-1:0]  wr_dat,
  output logic          rd_vld,
  input  logic          rd_rdy,
  output logic [W-1:0]  rd_dat,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          pop;
  logic          full;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop    = rd_rdy && rd_vld;
  assign full   = (cnt == CW'(DEPTH));
  assign rd_vld = (cnt != '0);
  assign rd_dat = mem[rd_ptr];
  assign count  = cnt;

  // Storage is reset too, so the read port shows zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_vld) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({wr_vld, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  wr_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(wr_vld && full));

endmodule

// fb_scanout: walks the RGB565 framebuffer row-major, unpacks to RGB888, streams pixels with sof/eol/eof.
// Latency: enable in IDLE -> first read next cycle -> first pixel valid 3 cycles after enable.
// Backpressure: pix_ready low stops reads once 2 pixels are buffered or in flight; nothing is dropped.
// Ports: clk/rst_n; enable (sampled in IDLE); fb_rd_en/fb_rd_addr/fb_rd_data BRAM read port
//        (1-cycle latency); pix_valid/pix_ready/pix_r/g/b/sof/eol/eof output stream;
//        busy (frame in progress); frame_done (pulse after the eof pixel is accepted).
module fb_scanout #(
  parameter int FB_WIDTH  = 64,
  parameter int FB_HEIGHT = 64,
  parameter int ADDR_W    = 12   // FB_WIDTH*FB_HEIGHT must fit in 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [15:0]       fb_rd_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [7:0]        pix_r,
  output logic [7:0]        pix_g,
  output logic [7:0]        pix_b,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              busy,
  output logic              frame_done
);

  localparam int NPIX = FB_WIDTH * FB_HEIGHT;
  localparam int XW   = (FB_WIDTH  > 1) ? $clog2(FB_WIDTH)  : 1;
  localparam int YW   = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       sof;
    logic       eol;
    logic       eof;
  } pix_t;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } meta_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t            state;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr;
  logic              inflight;   // read issued last cycle; its data is on fb_rd_data now
  meta_t             rd_meta;    // markers of the in-flight read
  logic              done_q;

  logic              issue;
  logic              pop;
  logic [1:0]        occ;
  logic [2:0]        occ_sum;
  logic              last_pix;
  meta_t             meta_n;
  pix_t              wr_pix;
  pix_t              head;

  assign pop      = pix_valid && pix_ready;
  assign occ_sum  = {1'b0, occ} + {2'b00, inflight};
  // count + inflight - pop < 2, rearranged so the 3-bit sum never goes negative.
  // Depends on this cycle's pix_ready, so the read strobe is combinational.
  assign issue    = (state == ST_RUN) && (occ_sum < (3'd2 + {2'b00, pop}));
  assign last_pix = (addr == ADDR_W'(NPIX - 1));

  assign meta_n.sof = (x == '0) && (y == '0);
  assign meta_n.eol = (x == XW'(FB_WIDTH - 1));
  assign meta_n.eof = last_pix;

  // RGB565 -> RGB888 by replicating the MSBs into the new low bits.
  assign wr_pix.r   = {fb_rd_data[15:11], fb_rd_data[15:13]};
  assign wr_pix.g   = {fb_rd_data[10:5],  fb_rd_data[10:9]};
  assign wr_pix.b   = {fb_rd_data[4:0],   fb_rd_data[4:2]};
  assign wr_pix.sof = rd_meta.sof;
  assign wr_pix.eol = rd_meta.eol;
  assign wr_pix.eof = rd_meta.eof;

  fb_fifo #(.W($bits(pix_t)), .DEPTH(2)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (inflight),
    .wr_dat (wr_pix),
    .rd_vld (pix_valid),
    .rd_rdy (pix_ready),
    .rd_dat (head),
    .count  (occ)
  );

  assign fb_rd_en   = issue;
  assign fb_rd_addr = addr;
  assign pix_r      = head.r;
  assign pix_g      = head.g;
  assign pix_b      = head.b;
  assign pix_sof    = head.sof;
  assign pix_eol    = head.eol;
  assign pix_eof    = head.eof;
  assign busy       = (state != ST_IDLE);
  assign frame_done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      x        <= '0;
      y        <= '0;
      addr     <= '0;
      inflight <= 1'b0;
      rd_meta  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      inflight <= issue;
      if (issue) rd_meta <= meta_n;

      case (state)
        ST_IDLE: begin
          if (enable) state <= ST_RUN;
        end
        ST_RUN: begin
          if (issue) begin
            if (last_pix) begin
              // Counters return to zero here so IDLE always restarts at pixel 0.
              x     <= '0;
              y     <= '0;
              addr  <= '0;
              state <= ST_DRAIN;
            end else begin
              addr <= addr + ADDR_W'(1);
              if (x == XW'(FB_WIDTH - 1)) begin
                x <= '0;
                y <= y + YW'(1);
              end else begin
                x <= x + XW'(1);
              end
            end
          end
        end
        ST_DRAIN: begin
          if (pop && head.eof) begin
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
`timescale 1ns/1ps
module tb_fb_scanout;
  localparam int W = 64;
  localparam int H = 64;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        fb_rd_en;
  logic [11:0] fb_rd_addr;
  logic [15:0] fb_rd_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        pix_sof, pix_eol, pix_eof;
  logic        busy;
  logic        frame_done;

  fb_scanout #(.FB_WIDTH(W), .FB_HEIGHT(H), .ADDR_W(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fb_rd_en   (fb_rd_en),
    .fb_rd_addr (fb_rd_addr),
    .fb_rd_data (fb_rd_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_r      (pix_r),
    .pix_g      (pix_g),
    .pix_b      (pix_b),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .pix_eof    (pix_eof),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Framebuffer BRAM model with one cycle of read latency.
  logic [15:0] mem [N];
  always @(posedge clk) if (fb_rd_en) fb_rd_data <= mem[fb_rd_addr];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int rd_cnt = 0;
  int mode = 0;        // 0: pix_ready high, 1: random pix_ready
  int stall_at = -1;   // absolute transfer index at which a 10-cycle stall begins
  logic [26:0] exp_q[$];

  int   g_first_rd, g_first_rd_addr, g_first_vld, g_first_xfer, g_eof, g_done;
  logic g_busy_done, g_busy_pre;

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got no event within bound, expected event", name);
  endtask

  function automatic logic [26:0] exp_pix(input logic [15:0] d, input int a);
    logic [7:0] r, g, b;
    r = {d[15:11], d[15:13]};
    g = {d[10:5], d[10:9]};
    b = {d[4:0], d[4:2]};
    return {r, g, b, (a == 0), ((a % W) == W - 1), (a == N - 1)};
  endfunction

  function automatic logic [63:0] outs();
    return {21'd0, fb_rd_en, fb_rd_addr, pix_valid, pix_r, pix_g, pix_b,
            pix_sof, pix_eol, pix_eof, busy, frame_done};
  endfunction

  task automatic push_frame_computed();
    for (int a = 0; a < N; a++) exp_q.push_back(exp_pix(mem[a], a));
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard on every transfer.
  initial forever begin
    logic [26:0] got, e;
    @(negedge clk);
    if (fb_rd_en) rd_cnt++;
    if (pix_valid && pix_ready) begin
      got = {pix_r, pix_g, pix_b, pix_sof, pix_eol, pix_eof};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pixel: got 0x%0h expected no transfer", got);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("pixel_%0d", xfer_cnt), got, e);
      end
      xfer_cnt++;
    end
  end

  // pix_ready driver.
  initial begin
    int stall_left = 0;
    int handled = -1;
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) begin
          check("stall_buffered", rd_cnt - xfer_cnt, 2);
          check("stall_valid_held", pix_valid, 1);
          pix_ready = 1'b1;
        end else begin
          pix_ready = 1'b0;
        end
      end else if (stall_at >= 0 && stall_at != handled && xfer_cnt == stall_at) begin
        handled    = stall_at;
        stall_left = 10;
        pix_ready  = 1'b0;
      end else if (mode == 1) begin
        pix_ready = ($urandom_range(0, 1) == 1);
      end else begin
        pix_ready = 1'b1;
      end
    end
  end

  // Watches until frame_done, recording first-event cycles.
  task automatic wait_done(input int budget);
    bit seen = 0;
    g_first_rd = -1; g_first_rd_addr = -1; g_first_vld = -1;
    g_first_xfer = -1; g_eof = -1; g_done = -1;
    g_busy_pre = 1'b0; g_busy_done = 1'b1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (fb_rd_en && g_first_rd < 0) begin
        g_first_rd = cyc;
        g_first_rd_addr = int'(fb_rd_addr);
      end
      if (pix_valid && g_first_vld < 0) g_first_vld = cyc;
      if (pix_valid && pix_ready && g_first_xfer < 0) g_first_xfer = cyc;
      if (pix_valid && pix_ready && pix_eof) g_eof = cyc;
      if (frame_done) begin
        g_done = cyc;
        g_busy_done = busy;
        seen = 1;
      end else begin
        g_busy_pre = busy;
      end
    end
    if (!seen) timeout("frame_done_wait");
  endtask

  task automatic check_idle(input string name);
    int rds = 0;
    int dns = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fb_rd_en) rds++;
      if (frame_done) dns++;
    end
    check({name, "_reads"}, rds, 0);
    check({name, "_extra_done"}, dns, 0);
    check({name, "_busy"}, busy, 0);
  endtask

  initial begin
    int t0, base;
    bit found;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check("reset_outputs", outs(), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 1: word = address, enable pulsed for one cycle, ready always high.
    for (int a = 0; a < N; a++) mem[a] = 16'(a);
    push_frame_computed();
    base = xfer_cnt;
    @(posedge clk); #1;
    enable = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    enable = 1'b0;
    wait_done(6000);
    check("f1_first_rd_lat", g_first_rd - t0, 1);
    check("f1_first_rd_addr", g_first_rd_addr, 0);
    check("f1_first_vld_lat", g_first_vld - t0, 3);
    check("f1_span", g_eof - g_first_xfer, N - 1);
    check("f1_done_after_eof", g_done - g_eof, 1);
    check("f1_busy_at_done", g_busy_done, 0);
    check("f1_busy_before_done", g_busy_pre, 1);
    check("f1_xfers", xfer_cnt - base, N);
    check_idle("f1_idle");
    check("f1_queue_empty", exp_q.size(), 0);

    // Frames 2 and 3: unpack vectors, 10-cycle stall at pixel 100, then random ready.
    mem[0] = 16'hF800; mem[1] = 16'h07E0; mem[2] = 16'h001F;
    mem[3] = 16'h8410; mem[4] = 16'h0000;
    for (int a = 5; a < N; a++) mem[a] = 16'((a * 40503) ^ 23130);
    exp_q.push_back({8'hFF, 8'h00, 8'h00, 3'b100});
    exp_q.push_back({8'h00, 8'hFF, 8'h00, 3'b000});
    exp_q.push_back({8'h00, 8'h00, 8'hFF, 3'b000});
    exp_q.push_back({8'h84, 8'h82, 8'h84, 3'b000});
    exp_q.push_back({8'h00, 8'h00, 8'h00, 3'b000});
    for (int a = 5; a < N; a++) exp_q.push_back(exp_pix(mem[a], a));
    push_frame_computed();
    base = xfer_cnt;
    stall_at = base + 100;
    @(posedge clk); #1;
    enable = 1'b1;
    wait_done(6000);
    check("f2_xfers", xfer_cnt - base, N);
    check("f2_queue_left", exp_q.size(), N);
    mode = 1;
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      if (fb_rd_en) begin
        found = 1;
        check("b2b_rd_lat", cyc - g_done, 1);
        check("b2b_rd_addr", fb_rd_addr, 0);
      end
    end
    if (!found) timeout("b2b_first_read");
    found = 0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk);
      if (xfer_cnt - base >= N + 500) found = 1;
    end
    if (!found) timeout("f3_progress");
    @(posedge clk); #1;
    enable = 1'b0;   // mid-frame: the frame must still complete
    wait_done(20000);
    mode = 0;
    check("f3_xfers", xfer_cnt - base, 2 * N);
    check("f3_queue_empty", exp_q.size(), 0);
    check_idle("f3_idle");

    // Frame 4: asynchronous reset at pixel 2000, then a clean restart.
    push_frame_computed();
    base = xfer_cnt;
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    found = 0;
    for (int i = 0; i < 6000 && !found; i++) begin
      @(negedge clk);
      if (xfer_cnt - base >= 2000) found = 1;
    end
    if (!found) timeout("f4_progress");
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async_outputs", outs(), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_held_outputs", outs(), 0);
    rst_n = 1'b1;
    push_frame_computed();
    base = xfer_cnt;
    @(posedge clk); #1;
    enable = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    enable = 1'b0;
    wait_done(6000);
    check("f5_first_rd_lat", g_first_rd - t0, 1);
    check("f5_first_rd_addr", g_first_rd_addr, 0);
    check("f5_xfers", xfer_cnt - base, N);
    check("f5_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
